// File: rtl/mem_stage.sv
// MEM pipeline stage: data-SRAM req/addr_ok/data_ok handshake,
// load alignment/extension and store lane steering.
module mem_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [107:0]      ex2mem_bus_i,
  output logic [69:0]       mem2wb_bus_o,
  input  logic              ctl_mem_valid_i,
  input  logic              ctl_mem_next_i,
  output logic              ctl_mem_over_o,
  output logic              ctl_mem_ale_o,
  output logic [4:0]        ctl_mem_dest_o,
  output logic [31:0]       ctl_mem_pc_o,
  output logic              data_req_o,
  output logic              data_wr_o,
  output logic [1:0]        data_size_o,
  output logic [DATA_W-1:0] data_addr_o,
  output logic [3:0]        data_wstrb_o,
  output logic [DATA_W-1:0] data_wdata_o,
  input  logic              data_addr_ok_i,
  input  logic [DATA_W-1:0] data_rdata_i,
  input  logic              data_data_ok_i
);

  typedef enum logic [1:0] {
    IDLE, REQ, WAIT, DONE
  } state_t;

  state_t state_q, state_d;

  logic [5:0]        mem_ctl;
  logic [31:0]       st_data;
  logic [31:0]       exe_result;
  logic [4:0]        rd_addr;
  logic              rd_we;
  logic [31:0]       pc;
  logic [DATA_W-1:0] ld_r;
  logic [DATA_W-1:0] ld_val;
  logic [31:0]       wb_result;
  logic [7:0]        ld_b;
  logic [15:0]       ld_h;
  logic [1:0]        off;
  logic              is_ld, is_st, uns;
  logic              sz_b, sz_h, sz_w;
  logic              memop, misal, ale;
  logic              req;
  logic              unused_rsvd;

  assign {mem_ctl, st_data, exe_result,
          rd_addr, rd_we, pc} = ex2mem_bus_i;

  assign is_ld       = mem_ctl[5];
  assign is_st       = mem_ctl[4];
  assign uns         = mem_ctl[1];
  assign unused_rsvd = mem_ctl[0];
  assign sz_b        = mem_ctl[3:2] == 2'b00;
  assign sz_h        = mem_ctl[3:2] == 2'b01;
  assign sz_w        = mem_ctl[3];
  assign off         = exe_result[1:0];

  assign memop = ctl_mem_valid_i & (is_ld | is_st);
  assign misal = (sz_h & off[0]) | (sz_w & |off);
  assign ale   = memop & misal;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ld_r    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == WAIT && data_data_ok_i && is_ld)
        ld_r <= data_rdata_i;
    end
  end

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    unique case (state_q)
      IDLE: begin
        req = memop & ~ale;
        if (req)
          state_d = data_addr_ok_i ? WAIT : REQ;
      end
      REQ: begin
        req = 1'b1;
        if (data_addr_ok_i)
          state_d = WAIT;
      end
      WAIT:
        if (data_data_ok_i)
          state_d = DONE;
      DONE:
        if (ctl_mem_next_i)
          state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ld_b = ld_r[{off, 3'b000} +: 8];
  assign ld_h = ld_r[{off[1], 4'b0000} +: 16];

  always_comb begin
    ld_val       = ld_r;
    data_wstrb_o = 4'b1111;
    data_wdata_o = st_data;
    unique case (1'b1)
      sz_b: begin
        ld_val       = {{24{~uns & ld_b[7]}}, ld_b};
        data_wstrb_o = 4'b0001 << off;
        data_wdata_o = {4{st_data[7:0]}};
      end
      sz_h: begin
        ld_val       = {{16{~uns & ld_h[15]}}, ld_h};
        data_wstrb_o = 4'b0011 << off;
        data_wdata_o = {2{st_data[15:0]}};
      end
      default: ;
    endcase
    if (!is_st)
      data_wstrb_o = 4'b0000;
  end

  always_comb begin
    wb_result = exe_result;
    if (ale)
      wb_result = '0;
    else if (memop && is_ld)
      wb_result = ld_val;
  end

  assign data_req_o  = req & ~rst_i;
  assign data_wr_o   = is_st;
  assign data_size_o = mem_ctl[3:2];
  assign data_addr_o = exe_result;

  assign ctl_mem_over_o = ctl_mem_valid_i &
    (~memop | ale | state_q == DONE);
  assign ctl_mem_ale_o  = ale;
  assign ctl_mem_dest_o = rd_addr & {5{ctl_mem_valid_i}};
  assign ctl_mem_pc_o   = pc;
  assign mem2wb_bus_o   = {wb_result, rd_addr, rd_we, pc};

  // An in-flight access must keep its instruction on the bus.
  assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q != IDLE) |-> ctl_mem_valid_i);

endmodule
